// File: rtl/hazard_interlock_ctrl.sv
// Scoreboard interlock beside the decode stage: issues, stalls or squashes the
// decode instruction, sequences the HALT drain and keeps hazard statistics.
module hazard_interlock_ctrl #(
   parameter int REG_WIDTH    = 5,
   parameter int REGISTER_NUM = 32,
   parameter int WB_LATENCY   = 2,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                 clock,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [REG_WIDTH-1:0] id_rs1,
   input  logic                 id_rs1_used,
   input  logic [REG_WIDTH-1:0] id_rs2,
   input  logic                 id_rs2_used,
   input  logic [REG_WIDTH-1:0] id_rd,
   input  logic                 id_reg_write,
   input  logic                 id_halt,
   input  logic                 branch_taken,
   output logic                 issue,
   output logic                 stall,
   output logic                 flush,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] stall_count,
   output logic [CNT_WIDTH-1:0] hazard_count,
   output logic [CNT_WIDTH-1:0] issued_count
);

   localparam int SB_WIDTH = $clog2(WB_LATENCY + 1);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t                  state;
   logic [SB_WIDTH-1:0]     sb_cnt  [REGISTER_NUM];
   logic [SB_WIDTH-1:0]     sb_next [REGISTER_NUM];
   logic [REGISTER_NUM-1:0] busy;
   logic                    hz;
   logic                    hazard_stall;
   logic                    prev_hazard_stall;
   logic                    drain_done;

   // Hazard check deliberately uses the pre-update counters so rd==rs never self-stalls
   always_comb begin
      for (int r = 0; r < REGISTER_NUM; r++) begin
         busy[r] = (sb_cnt[r] != '0);
      end
      hz = id_valid & ((id_rs1_used & busy[id_rs1]) | (id_rs2_used & busy[id_rs2]));
   end

   always_comb begin
      issue = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      if (rst) begin
         issue = 1'b0;
      end else if (state != RUN) begin
         stall = 1'b1;
      end else if (branch_taken) begin
         flush = 1'b1;
      end else if (hz) begin
         stall = 1'b1;
      end else if (id_valid) begin
         issue = 1'b1;
      end
   end

   assign hazard_stall = (state == RUN) & ~branch_taken & hz & ~rst;

   // A fresh load of the destination wins over the decrement in the same cycle
   always_comb begin
      for (int r = 0; r < REGISTER_NUM; r++) begin
         sb_next[r] = (sb_cnt[r] != '0) ? sb_cnt[r] - SB_WIDTH'(1) : '0;
      end
      if (issue && id_reg_write) begin
         sb_next[id_rd] = SB_WIDTH'(WB_LATENCY);
      end
      drain_done = 1'b1;
      for (int r = 0; r < REGISTER_NUM; r++) begin
         if (sb_next[r] != '0) begin
            drain_done = 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state             <= RUN;
         halted            <= 1'b0;
         prev_hazard_stall <= 1'b0;
         stall_count       <= '0;
         hazard_count      <= '0;
         issued_count      <= '0;
         for (int r = 0; r < REGISTER_NUM; r++) begin
            sb_cnt[r] <= '0;
         end
      end else begin
         sb_cnt            <= sb_next;
         prev_hazard_stall <= hazard_stall;
         if (hazard_stall && stall_count != '1) begin
            stall_count <= stall_count + CNT_WIDTH'(1);
         end
         if (hazard_stall && !prev_hazard_stall && hazard_count != '1) begin
            hazard_count <= hazard_count + CNT_WIDTH'(1);
         end
         if (issue && issued_count != '1) begin
            issued_count <= issued_count + CNT_WIDTH'(1);
         end
         case (state)
            RUN: begin
               if (issue && id_halt) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (drain_done) begin
                  state  <= HALTED;
                  halted <= 1'b1;
               end
            end
            default: begin
               state <= HALTED;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_interlock_ctrl.sv
// Directed bench for hazard_interlock_ctrl: a vector table for issue/stall/flush
// behaviour plus hand sequences for halt drain, reset mid-drain and saturation.
module tb_hazard_interlock_ctrl;

   logic        clock = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [4:0]  id_rs1;
   logic        id_rs1_used;
   logic [4:0]  id_rs2;
   logic        id_rs2_used;
   logic [4:0]  id_rd;
   logic        id_reg_write;
   logic        id_halt;
   logic        branch_taken;
   logic        issue, stall, flush, halted;
   logic [31:0] stall_count, hazard_count, issued_count;
   logic        s_issue, s_stall, s_flush, s_halted;
   logic [1:0]  s_stall_count, s_hazard_count, s_issued_count;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic       valid;
      logic [4:0] rs1;
      logic       rs1_used;
      logic [4:0] rs2;
      logic       rs2_used;
      logic [4:0] rd;
      logic       reg_write;
      logic       halt;
      logic       br;
      logic       exp_issue;
      logic       exp_stall;
      logic       exp_flush;
      int         exp_issued;
      int         exp_stalls;
      int         exp_hazards;
   } vec_t;

   vec_t vecs[$];

   always #5 clock = ~clock;

   hazard_interlock_ctrl dut (
      .clock(clock), .rst(rst), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
      .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_halt(id_halt),
      .branch_taken(branch_taken),
      .issue(issue), .stall(stall), .flush(flush), .halted(halted),
      .stall_count(stall_count), .hazard_count(hazard_count), .issued_count(issued_count)
   );

   // Narrow counters so saturation is reachable in a handful of cycles
   hazard_interlock_ctrl #(.CNT_WIDTH(2)) dut_small (
      .clock(clock), .rst(rst), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
      .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_halt(id_halt),
      .branch_taken(branch_taken),
      .issue(s_issue), .stall(s_stall), .flush(s_flush), .halted(s_halted),
      .stall_count(s_stall_count), .hazard_count(s_hazard_count), .issued_count(s_issued_count)
   );

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input int valid, input int rs1, input int u1, input int rs2, input int u2,
                                 input int rd, input int rw, input int halt, input int br);
      id_valid     = 1'(valid);
      id_rs1       = 5'(rs1);
      id_rs1_used  = 1'(u1);
      id_rs2       = 5'(rs2);
      id_rs2_used  = 1'(u2);
      id_rd        = 5'(rd);
      id_reg_write = 1'(rw);
      id_halt      = 1'(halt);
      branch_taken = 1'(br);
   endtask

   task automatic add_vec(input int valid, input int rs1, input int u1, input int rs2, input int u2,
                          input int rd, input int rw, input int halt, input int br,
                          input int e_issue, input int e_stall, input int e_flush,
                          input int e_issued, input int e_stalls, input int e_hazards);
      vec_t v;
      v.valid = 1'(valid);  v.rs1 = 5'(rs1);  v.rs1_used = 1'(u1);
      v.rs2 = 5'(rs2);      v.rs2_used = 1'(u2);
      v.rd = 5'(rd);        v.reg_write = 1'(rw);
      v.halt = 1'(halt);    v.br = 1'(br);
      v.exp_issue = 1'(e_issue);  v.exp_stall = 1'(e_stall);  v.exp_flush = 1'(e_flush);
      v.exp_issued = e_issued;    v.exp_stalls = e_stalls;    v.exp_hazards = e_hazards;
      vecs.push_back(v);
   endtask

   task automatic idle();
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // Counter columns hold values accumulated by the rows before each one
      add_vec(1, 1, 1, 2, 1, 3, 1, 0, 0,   1, 0, 0,  0, 0, 0);
      add_vec(1, 3, 1, 0, 0, 4, 1, 0, 0,   0, 1, 0,  1, 0, 0);
      add_vec(1, 3, 1, 0, 0, 4, 1, 0, 0,   0, 1, 0,  1, 1, 1);
      add_vec(1, 3, 1, 0, 0, 4, 1, 0, 0,   1, 0, 0,  1, 2, 1);
      add_vec(1, 4, 0, 4, 0, 5, 1, 0, 0,   1, 0, 0,  2, 2, 1);
      add_vec(1, 1, 1, 2, 1, 6, 1, 0, 0,   1, 0, 0,  3, 2, 1);
      add_vec(1, 5, 1, 0, 0, 8, 1, 0, 0,   0, 1, 0,  4, 2, 1);
      add_vec(1, 5, 1, 0, 0, 8, 1, 0, 0,   1, 0, 0,  4, 3, 2);
      add_vec(1, 0, 0, 0, 0, 5, 1, 0, 0,   1, 0, 0,  5, 3, 2);
      add_vec(1, 0, 1, 5, 0, 10, 0, 0, 0,  1, 0, 0,  6, 3, 2);
      add_vec(1, 0, 0, 0, 0, 11, 1, 0, 0,  1, 0, 0,  7, 3, 2);
      add_vec(1, 11, 1, 0, 0, 7, 1, 0, 1,  0, 0, 1,  8, 3, 2);
      add_vec(1, 7, 1, 0, 0, 12, 0, 0, 0,  1, 0, 0,  8, 3, 2);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  9, 3, 2);

      rst = 1'b1;
      idle();
      @(negedge clock);
      @(negedge clock);
      rst = 1'b0;
      #1;
      check_output("reset_halted", halted, 0);
      check_output("reset_issue", issue, 0);
      check_output("reset_stall", stall, 0);
      check_output("reset_flush", flush, 0);
      check_output("reset_stall_count", stall_count, 0);
      check_output("reset_hazard_count", hazard_count, 0);
      check_output("reset_issued_count", issued_count, 0);

      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].valid, vecs[i].rs1, vecs[i].rs1_used, vecs[i].rs2, vecs[i].rs2_used,
                        vecs[i].rd, vecs[i].reg_write, vecs[i].halt, vecs[i].br);
         #1;
         check_output($sformatf("vec%0d_issue", i), issue, vecs[i].exp_issue);
         check_output($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
         check_output($sformatf("vec%0d_flush", i), flush, vecs[i].exp_flush);
         check_output($sformatf("vec%0d_halted", i), halted, 0);
         check_output($sformatf("vec%0d_issued_count", i), issued_count, vecs[i].exp_issued);
         check_output($sformatf("vec%0d_stall_count", i), stall_count, vecs[i].exp_stalls);
         check_output($sformatf("vec%0d_hazard_count", i), hazard_count, vecs[i].exp_hazards);
         @(negedge clock);
      end

      // Halt drain: producer r2 then HALT; halted once r2 has retired
      apply_stimulus(1, 0, 0, 0, 0, 2, 1, 0, 0);
      #1; check_output("drain_producer_issue", issue, 1);
      @(negedge clock);
      apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
      #1; check_output("drain_halt_issue", issue, 1);
      @(negedge clock);
      apply_stimulus(1, 1, 1, 0, 0, 3, 1, 0, 0);
      #1;
      check_output("drain_stall", stall, 1);
      check_output("drain_no_issue", issue, 0);
      check_output("drain_not_halted", halted, 0);
      @(negedge clock);
      #1;
      check_output("halted_rise", halted, 1);
      check_output("halted_stall", stall, 1);
      check_output("halted_issued_count", issued_count, 11);
      check_output("halted_stall_count", stall_count, 3);
      @(negedge clock);
      idle();
      @(negedge clock);
      apply_stimulus(1, 0, 0, 0, 0, 4, 1, 0, 0);
      #1;
      check_output("halted_pulse_no_issue", issue, 0);
      @(negedge clock);
      #1;
      check_output("halted_hold", halted, 1);
      check_output("halted_issued_hold", issued_count, 11);

      // Reset mid-drain with r2 still pending, then a no-pending halt
      rst = 1'b1;
      idle();
      @(negedge clock);
      rst = 1'b0;
      #1;
      check_output("rst_from_halted", halted, 0);
      check_output("rst_issued_count", issued_count, 0);
      @(negedge clock);
      apply_stimulus(1, 0, 0, 0, 0, 2, 1, 0, 0);
      @(negedge clock);
      apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clock);
      idle();
      #1;
      check_output("mid_drain_stall", stall, 1);
      rst = 1'b1;
      @(negedge clock);
      rst = 1'b0;
      apply_stimulus(1, 2, 1, 0, 0, 0, 0, 0, 0);
      #1;
      check_output("post_rst_reader_issue", issue, 1);
      check_output("post_rst_halted", halted, 0);
      check_output("post_rst_stall_count", stall_count, 0);
      check_output("post_rst_hazard_count", hazard_count, 0);
      check_output("post_rst_issued_count", issued_count, 0);
      @(negedge clock);
      apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
      #1; check_output("quick_halt_issue", issue, 1);
      @(negedge clock);
      idle();
      #1;
      check_output("quick_drain_stall", stall, 1);
      check_output("quick_drain_not_halted", halted, 0);
      @(negedge clock);
      #1;
      check_output("quick_halted", halted, 1);

      // Saturation: four hazard episodes of two stalls each
      rst = 1'b1;
      @(negedge clock);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(1, 0, 0, 0, 0, 1, 1, 0, 0);
         @(negedge clock);
         apply_stimulus(1, 1, 1, 0, 0, 9, 0, 0, 0);
         @(negedge clock);
         @(negedge clock);
         #1;
         check_output($sformatf("sat_rep%0d_issue", k), issue, 1);
         @(negedge clock);
      end
      idle();
      #1;
      check_output("sat_main_stall_count", stall_count, 8);
      check_output("sat_main_hazard_count", hazard_count, 4);
      check_output("sat_main_issued_count", issued_count, 8);
      check_output("sat_small_stall_count", s_stall_count, 3);
      check_output("sat_small_hazard_count", s_hazard_count, 3);
      check_output("sat_small_issued_count", s_issued_count, 3);
      check_output("sat_small_halted", s_halted, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
